// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit: request control
// codes, FSM states, default DRAM base and an access-size helper.
package dmem_pkg;

  localparam logic [63:0] DRAM_BASE_DEF = 64'h8000_0000;

  typedef enum logic [2:0] {
    RD_NONE = 3'd0, RD_LB = 3'd1, RD_LBU = 3'd2, RD_LH = 3'd3,
    RD_LHU  = 3'd4, RD_LW = 3'd5, RD_LWU = 3'd6, RD_LD = 3'd7
  } rd_ctrl_e;

  typedef enum logic [2:0] {
    WR_NONE = 3'd0, WR_SB = 3'd1, WR_SH = 3'd2, WR_SW = 3'd3, WR_SD = 3'd4
  } wr_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2, S_RESP = 2'd3
  } state_e;

  // log2 of the access size in bytes; loads take priority over stores
  function automatic logic [1:0] acc_size(logic [2:0] rd, logic [2:0] wr);
    logic [1:0] s;
    s = 2'd0;
    case (rd)
      RD_LB, RD_LBU: s = 2'd0;
      RD_LH, RD_LHU: s = 2'd1;
      RD_LW, RD_LWU: s = 2'd2;
      RD_LD:         s = 2'd3;
      default: begin
        case (wr)
          WR_SH:   s = 2'd1;
          WR_SW:   s = 2'd2;
          WR_SD:   s = 2'd3;
          default: s = 2'd0;
        endcase
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane datapath: load extract with sign/zero extension
// and store lane merge into an existing dword.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  logic [2:0]  rd_ctrl,
  input  logic [2:0]  wr_ctrl,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);

  logic [63:0] rsh;
  logic [63:0] wsh;
  logic [7:0]  be_base;
  logic [7:0]  be;

  assign rsh = dword >> {off, 3'b000};
  assign wsh = wdata << {off, 3'b000};
  assign be  = be_base << off;

  // bring the addressed lane down to bit 0 and extend it
  always_comb begin
    load_data = '0;
    case (rd_ctrl)
      RD_LB:   load_data = {{56{rsh[7]}}, rsh[7:0]};
      RD_LBU:  load_data = {56'd0, rsh[7:0]};
      RD_LH:   load_data = {{48{rsh[15]}}, rsh[15:0]};
      RD_LHU:  load_data = {48'd0, rsh[15:0]};
      RD_LW:   load_data = {{32{rsh[31]}}, rsh[31:0]};
      RD_LWU:  load_data = {32'd0, rsh[31:0]};
      RD_LD:   load_data = rsh;
      default: load_data = '0;
    endcase
  end

  // byte enables before shifting to the target offset
  always_comb begin
    be_base = 8'h00;
    case (wr_ctrl)
      WR_SB:   be_base = 8'h01;
      WR_SH:   be_base = 8'h03;
      WR_SW:   be_base = 8'h0F;
      WR_SD:   be_base = 8'hFF;
      default: be_base = 8'h00;
    endcase
  end

  for (genvar b = 0; b < 8; b++) begin : g_lane
    assign store_data[8*b +: 8] = be[b] ? wsh[8*b +: 8] : dword[8*b +: 8];
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the core MEM stage and a 64-bit dword DRAM.
// Sub-dword stores are done as read-modify-write of the whole dword.
// Optional macro DMEM_MISALIGN_TRAP_EN: when defined, naturally misaligned
// accesses fault; otherwise the low address bits are forced to alignment.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter logic [63:0] DRAM_BASE = DRAM_BASE_DEF,
  parameter int          AW        = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_rd_ctrl,
  input  logic [2:0]    req_wr_ctrl,
  input  logic [63:0]   req_addr,
  input  logic [63:0]   req_wdata,
  output logic          resp_valid,
  output logic [63:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  state_e        state, state_nx;
  logic [2:0]    rd_q, wr_q, off_q;
  logic [63:0]   wdata_q, rbuf_q;
  logic          err_q;
  logic [AW-1:0] addr_q;

  logic [63:0]   rel;
  logic          in_range, bad_ctl, misal, fault, no_op, accept;
  logic [1:0]    size;
  logic [2:0]    amask, off_acc;
  logic [63:0]   load_data, store_data;

  // request decode, evaluated against the live request in IDLE
  assign rel      = req_addr - DRAM_BASE;
  assign in_range = (req_addr >= DRAM_BASE) && ((rel >> (AW + 3)) == 64'd0);
  assign bad_ctl  = ((req_rd_ctrl != RD_NONE) && (req_wr_ctrl != WR_NONE)) ||
                    (req_wr_ctrl > WR_SD);
  assign no_op    = (req_rd_ctrl == RD_NONE) && (req_wr_ctrl == WR_NONE);
  assign size     = acc_size(req_rd_ctrl, req_wr_ctrl);
  assign amask    = (size == 2'd0) ? 3'b000 :
                    (size == 2'd1) ? 3'b001 :
                    (size == 2'd2) ? 3'b011 : 3'b111;
  assign misal    = |(req_addr[2:0] & amask);
  assign accept   = req_valid && (state == S_IDLE);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault   = !in_range || bad_ctl || misal;
  assign off_acc = req_addr[2:0];
`else
  assign fault   = !in_range || bad_ctl;
  assign off_acc = req_addr[2:0] & ~amask;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // next state: faults and no-ops skip DRAM, SD skips the read
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (fault || no_op)          state_nx = S_RESP;
          else if (req_wr_ctrl == WR_SD) state_nx = S_WRITE;
          else                         state_nx = S_READ;
        end
      end
      S_READ:  state_nx = (wr_q != WR_NONE) ? S_WRITE : S_RESP;
      S_WRITE: state_nx = S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end

  // request latches, DRAM index and read capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rbuf_q  <= '0;
    end else begin
      if (accept) begin
        rd_q    <= req_rd_ctrl;
        wr_q    <= req_wr_ctrl;
        off_q   <= off_acc;
        wdata_q <= req_wdata;
        err_q   <= fault;
        // index only moves when DRAM is actually touched
        if (!fault && !no_op) addr_q <= rel[AW+2:3];
      end
      if (state == S_READ) rbuf_q <= mem_rdata;
    end
  end

  dmem_lane_unit u_lane (
    .dword      (rbuf_q),
    .wdata      (wdata_q),
    .off        (off_q),
    .rd_ctrl    (rd_q),
    .wr_ctrl    (wr_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q) ? load_data : 64'd0;
  // decoded from state so an async reset removes the write at once
  assign mem_we     = (state == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = mem_we ? store_data : 64'd0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed scoreboard bench for dmem_lsu with a behavioural DRAM model.
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_rd_ctrl = '0;
  logic [2:0]    req_wr_ctrl = '0;
  logic [63:0]   req_addr = '0;
  logic [63:0]   req_wdata = '0;
  logic          resp_valid;
  logic [63:0]   resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;

  logic [63:0] dram [0:(1<<AW)-1];

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          we;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  dmem_lsu #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_ctrl(req_rd_ctrl), .req_wr_ctrl(req_wr_ctrl),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dram[mem_addr];
  always @(posedge clk) if (mem_we) dram[mem_addr] <= mem_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [2:0] rd, input logic [2:0] wr,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] er, input logic ee, input int el, input int ew);
    exp_t e;
    int lat, we;
    logic got;
    e.rdata = er; e.err = ee; e.lat = el; e.we = ew;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, " ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_rd_ctrl = rd; req_wr_ctrl = wr;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0; req_rd_ctrl = '0; req_wr_ctrl = '0;
    lat = 0; we = 0; got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (mem_we) we++;
      if (resp_valid) begin got = 1'b1; break; end
    end
    e = sb.pop_front();
    chk({tag, " resp_seen"}, {63'd0, got}, 64'd1);
    if (got) begin
      chk({tag, " rdata"}, resp_rdata, e.rdata);
      chk({tag, " err"}, {63'd0, resp_err}, {63'd0, e.err});
      chk({tag, " latency"}, 64'(lat), 64'(e.lat));
      chk({tag, " we_count"}, 64'(we), 64'(e.we));
    end
  endtask

  initial begin
    logic got;
    for (int i = 0; i < (1<<AW); i++) dram[i] = 64'd0;
    dram[0]        = 64'h0123_4567_89AB_CDEF;
    dram[1]        = 64'h1122_3344_5566_7788;
    dram[3]        = 64'hF00D_CAFE_8765_4321;
    dram[5]        = 64'h1111_1111_1111_1111;
    dram[6]        = 64'h5555_5555_5555_5555;
    dram[(1<<AW)-1] = 64'hDEAD_BEEF_0BAD_F00D;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready",  {63'd0, req_ready},  64'd1);
    chk("rst rvalid", {63'd0, resp_valid}, 64'd0);
    chk("rst err",    {63'd0, resp_err},   64'd0);
    chk("rst rdata",  resp_rdata, 64'd0);
    chk("rst we",     {63'd0, mem_we},     64'd0);
    chk("rst maddr",  64'(mem_addr), 64'd0);
    chk("rst wdata",  mem_wdata, 64'd0);
    @(negedge clk) rst = 1'b1;

    // loads
    do_req("ld", RD_LD, WR_NONE, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 2, 0);
    dram[1] = 64'h8077_6655_4433_2211;
    do_req("lb",  RD_LB,  WR_NONE, 64'h8000_000F, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 0);
    do_req("lbu", RD_LBU, WR_NONE, 64'h8000_000F, 64'd0, 64'h0000_0000_0000_0080, 1'b0, 2, 0);
    do_req("lwu", RD_LWU, WR_NONE, 64'h8000_001C, 64'd0, 64'h0000_0000_F00D_CAFE, 1'b0, 2, 0);
    do_req("lh",  RD_LH,  WR_NONE, 64'h8000_001A, 64'd0, 64'hFFFF_FFFF_FFFF_8765, 1'b0, 2, 0);
    do_req("lhlo", RD_LH, WR_NONE, 64'h8000_0018, 64'd0, 64'h0000_0000_0000_4321, 1'b0, 2, 0);
    do_req("ld_last", RD_LD, WR_NONE, 64'h8000_FFF8, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 2, 0);

    // stores
    do_req("sh", RD_NONE, WR_SH, 64'h8000_0012, 64'h1234_5678_0000_BEEF, 64'd0, 1'b0, 3, 1);
    chk("sh dram", dram[2], 64'h0000_0000_BEEF_0000);
    do_req("lhu_back", RD_LHU, WR_NONE, 64'h8000_0012, 64'd0, 64'h0000_0000_0000_BEEF, 1'b0, 2, 0);
    do_req("sb", RD_NONE, WR_SB, 64'h8000_0029, 64'hFFFF_FFFF_FFFF_FFAB, 64'd0, 1'b0, 3, 1);
    chk("sb dram", dram[5], 64'h1111_1111_1111_AB11);
    do_req("sd", RD_NONE, WR_SD, 64'h8000_0020, 64'hCAFE_F00D_1234_5678, 64'd0, 1'b0, 2, 1);
    chk("sd dram", dram[4], 64'hCAFE_F00D_1234_5678);

    // faults and no-op
    do_req("sw_low",  RD_NONE, WR_SW, 64'h7FFF_FFF8, 64'hFFFF_FFFF, 64'd0, 1'b1, 1, 0);
    do_req("ld_high", RD_LD, WR_NONE, 64'h8001_0000, 64'd0, 64'd0, 1'b1, 1, 0);
    do_req("sd_high", RD_NONE, WR_SD, 64'h8001_0000, 64'd1, 64'd0, 1'b1, 1, 0);
    do_req("rd_wr",   RD_LW, WR_SW, 64'h8000_0000, 64'd0, 64'd0, 1'b1, 1, 0);
    do_req("wr_ill",  RD_NONE, 3'd5, 64'h8000_0000, 64'd0, 64'd0, 1'b1, 1, 0);
    do_req("noop",    RD_NONE, WR_NONE, 64'h8000_0000, 64'd0, 64'd0, 1'b0, 1, 0);
    chk("dram0 intact", dram[0], 64'h0123_4567_89AB_CDEF);

    // misaligned word load
`ifdef DMEM_MISALIGN_TRAP_EN
    do_req("lw_mis", RD_LW, WR_NONE, 64'h8000_0002, 64'd0, 64'd0, 1'b1, 1, 0);
`else
    do_req("lw_mis", RD_LW, WR_NONE, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 2, 0);
`endif

    // reset asserted during the write phase of an SB
    @(negedge clk);
    req_valid = 1'b1; req_rd_ctrl = RD_NONE; req_wr_ctrl = WR_SB;
    req_addr = 64'h8000_0030; req_wdata = 64'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0; req_wr_ctrl = '0;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_we) begin got = 1'b1; break; end
    end
    chk("rstwr we_seen", {63'd0, got}, 64'd1);
    rst = 1'b0;
    #1 chk("rstwr we_drop", {63'd0, mem_we}, 64'd0);
    @(posedge clk);
    #1 chk("rstwr dram", dram[6], 64'h5555_5555_5555_5555);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("rstwr ready",  {63'd0, req_ready},  64'd1);
    chk("rstwr rvalid", {63'd0, resp_valid}, 64'd0);

    // unit still works after the mid-op reset
    do_req("post_rst", RD_LD, WR_NONE, 64'h8000_0030, 64'd0, 64'h5555_5555_5555_5555, 1'b0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
